cosim_commit_buffer: RTL and testbench

Multi-lane retire buffer between the DUT core and the Spike cosim checker. Accepts up to NumRet retired instructions per cycle, each with PC and optional register write (and, when configured, memory write); compacts valid lanes into a circular FIFO; drains one entry per cycle with a sequence number. The testbench checker pops entries, calls `step()` once per entry, and compares against `get_pc`, `get_log_reg_write` and `get_log_mem_write`. It replaces the single-retire, one-entry-per-call flow with a parametrised, buffered, superscalar-capable stage.

---
 rtl/cosim_pkg.sv | 30 +++
 rtl/cosim_lane_compact.sv | 23 ++
 rtl/cosim_commit_buffer.sv | 134 +++++++++++++
 tb/tb_cosim_commit_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_pkg.sv
// Shared cosim commit-log types: register/memory log items and the buffered commit entry.
// COSIM_MEM_LOG_EN adds memory-write fields to commit_entry_t.
package cosim_pkg;

  localparam int unsigned XREG_W = 32;

  typedef logic [4:0] reg_t;

  typedef struct packed {
    reg_t              addr;
    logic [XREG_W-1:0] value;
  } commit_log_reg_item_t;

  typedef struct packed {
    logic [XREG_W-1:0] addr;
    logic [3:0]        len;
    logic [XREG_W-1:0] value;
  } commit_log_mem_item_t;

  typedef struct packed {
    logic [XREG_W-1:0]    pc;
    logic                 reg_we;
    commit_log_reg_item_t reg_item;
`ifdef COSIM_MEM_LOG_EN
    logic                 mem_we;
    commit_log_mem_item_t mem_item;
`endif
  } commit_entry_t;

endpackage

// File: rtl/cosim_lane_compact.sv
// Prefix count over the retire-valid lanes: per-lane FIFO slot offset and total pushed.
module cosim_lane_compact #(
  parameter int unsigned NumRet = 2
) (
  input  logic [NumRet-1:0]                        valid_i,
  output logic [NumRet-1:0][$clog2(NumRet+1)-1:0]  offset_o,
  output logic [$clog2(NumRet+1)-1:0]              total_o
);

  localparam int unsigned LaneW = $clog2(NumRet + 1);

  always_comb begin : p_prefix
    logic [LaneW-1:0] acc;
    acc      = '0;
    offset_o = '0;
    for (int unsigned i = 0; i < NumRet; i++) begin
      offset_o[i] = acc;
      acc         = acc + LaneW'(valid_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/cosim_commit_buffer.sv
// Multi-lane retire buffer feeding the cosim checker: compacts valid lanes into a circular
// FIFO and drains one sequenced entry per cycle. COSIM_MEM_LOG_EN adds memory-write logging.
module cosim_commit_buffer
  import cosim_pkg::*;
#(
  parameter int unsigned NumRet = 2,
  parameter int unsigned Depth  = 16,
  parameter int unsigned SeqW   = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumRet-1:0]                 ret_valid_i,
  input  logic [NumRet-1:0][XREG_W-1:0]     ret_pc_i,
  input  logic [NumRet-1:0]                 ret_reg_we_i,
  input  commit_log_reg_item_t [NumRet-1:0] ret_reg_i,
`ifdef COSIM_MEM_LOG_EN
  input  logic [NumRet-1:0]                 ret_mem_we_i,
  input  commit_log_mem_item_t [NumRet-1:0] ret_mem_i,
  output logic                              out_mem_we_o,
  output commit_log_mem_item_t              out_mem_o,
`endif
  output logic                              ret_ready_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [XREG_W-1:0]                 out_pc_o,
  output logic                              out_reg_we_o,
  output commit_log_reg_item_t              out_reg_o,
  output logic [SeqW-1:0]                   out_seq_o,
  output logic [$clog2(Depth+1)-1:0]        count_o,
  output logic                              overflow_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned LaneW = $clog2(NumRet + 1);

  commit_entry_t                   mem_q [Depth];
  logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                 count_q, count_d;
  logic [SeqW-1:0]                 seq_q, seq_d;
  logic                            ovf_q, ovf_d;
  logic [NumRet-1:0][LaneW-1:0]    lane_off;
  logic [LaneW-1:0]                push_cnt;
  logic [NumRet-1:0][PtrW-1:0]     lane_slot;
  commit_entry_t [NumRet-1:0]      lane_entry;
  commit_entry_t                   head;
  logic                            push, pop;

  cosim_lane_compact #(.NumRet(NumRet)) u_compact (
    .valid_i  (ret_valid_i),
    .offset_o (lane_off),
    .total_o  (push_cnt)
  );

  // Space check uses registered count only; a same-cycle pop earns no credit.
  assign ret_ready_o = (count_q <= CntW'(Depth - NumRet));
  assign out_valid_o = (count_q != '0);
  assign push        = ret_ready_o && (|ret_valid_i);
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    for (int unsigned i = 0; i < NumRet; i++) begin
      lane_slot[i]           = wr_ptr_q + PtrW'(lane_off[i]);
      lane_entry[i]          = '0;
      lane_entry[i].pc       = ret_pc_i[i];
      lane_entry[i].reg_we   = ret_reg_we_i[i];
      lane_entry[i].reg_item = ret_reg_i[i];
`ifdef COSIM_MEM_LOG_EN
      lane_entry[i].mem_we   = ret_mem_we_i[i];
      lane_entry[i].mem_item = ret_mem_i[i];
`endif
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(push_cnt);
      count_d  = count_d + CntW'(push_cnt);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      seq_d    = seq_q + SeqW'(1);
      count_d  = count_d - CntW'(1);
    end
    if ((|ret_valid_i) && !ret_ready_o) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      if (push) begin
        for (int unsigned i = 0; i < NumRet; i++) begin
          if (ret_valid_i[i]) begin
            mem_q[lane_slot[i]] <= lane_entry[i];
          end
        end
      end
    end
  end

  // Head is read straight from storage; contents are meaningless while empty.
  assign head         = mem_q[rd_ptr_q];
  assign out_pc_o     = head.pc;
  assign out_reg_we_o = head.reg_we;
  assign out_reg_o    = head.reg_item;
`ifdef COSIM_MEM_LOG_EN
  assign out_mem_we_o = head.mem_we;
  assign out_mem_o    = head.mem_item;
`endif
  assign out_seq_o    = seq_q;
  assign count_o      = count_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_cosim_commit_buffer.sv
// Self-checking bench for cosim_commit_buffer against a queue-based reference model.
module tb_cosim_commit_buffer;
  import cosim_pkg::*;

  localparam int unsigned NumRet = 2;
  localparam int unsigned Depth  = 16;
  localparam int unsigned SeqW   = 32;
  localparam int unsigned CntW   = $clog2(Depth + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NumRet-1:0]                 ret_valid;
  logic [NumRet-1:0][XREG_W-1:0]     ret_pc;
  logic [NumRet-1:0]                 ret_reg_we;
  commit_log_reg_item_t [NumRet-1:0] ret_reg;
`ifdef COSIM_MEM_LOG_EN
  logic [NumRet-1:0]                 ret_mem_we;
  commit_log_mem_item_t [NumRet-1:0] ret_mem;
  logic                              out_mem_we;
  commit_log_mem_item_t              out_mem;
`endif
  logic                              ret_ready, out_valid, out_ready;
  logic [XREG_W-1:0]                 out_pc;
  logic                              out_reg_we;
  commit_log_reg_item_t              out_reg;
  logic [SeqW-1:0]                   out_seq;
  logic [CntW-1:0]                   count;
  logic                              ovf;

  cosim_commit_buffer #(.NumRet(NumRet), .Depth(Depth), .SeqW(SeqW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ret_valid_i  (ret_valid),
    .ret_pc_i     (ret_pc),
    .ret_reg_we_i (ret_reg_we),
    .ret_reg_i    (ret_reg),
`ifdef COSIM_MEM_LOG_EN
    .ret_mem_we_i (ret_mem_we),
    .ret_mem_i    (ret_mem),
    .out_mem_we_o (out_mem_we),
    .out_mem_o    (out_mem),
`endif
    .ret_ready_o  (ret_ready),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_pc_o     (out_pc),
    .out_reg_we_o (out_reg_we),
    .out_reg_o    (out_reg),
    .out_seq_o    (out_seq),
    .count_o      (count),
    .overflow_o   (ovf)
  );

  int            n_chk  = 0;
  int            n_fail = 0;
  commit_entry_t model_q[$];
  int unsigned   model_seq;
  bit            model_ovf;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic commit_entry_t lane_entry(input int unsigned i);
    commit_entry_t e;
    e          = '0;
    e.pc       = ret_pc[i];
    e.reg_we   = ret_reg_we[i];
    e.reg_item = ret_reg[i];
`ifdef COSIM_MEM_LOG_EN
    e.mem_we   = ret_mem_we[i];
    e.mem_item = ret_mem[i];
`endif
    return e;
  endfunction

  task automatic set_lane(input int unsigned i, input logic [XREG_W-1:0] pc);
    ret_pc[i]     = pc;
    ret_reg_we[i] = 1'($urandom);
    ret_reg[i]    = {5'($urandom), 32'($urandom)};
`ifdef COSIM_MEM_LOG_EN
    ret_mem_we[i] = 1'($urandom);
    ret_mem[i]    = {32'($urandom), 4'($urandom), 32'($urandom)};
`endif
  endtask

  task automatic check_state();
    commit_entry_t h;
    chk("count", 128'(count), 128'(model_q.size()));
    chk("ready", 128'(ret_ready), 128'(model_q.size() + NumRet <= Depth));
    chk("valid", 128'(out_valid), 128'(model_q.size() > 0));
    chk("overflow", 128'(ovf), 128'(model_ovf));
    chk("seq", 128'(out_seq), 128'(model_seq));
    if (model_q.size() > 0) begin
      h = model_q[0];
      chk("pc", 128'(out_pc), 128'(h.pc));
      chk("reg_we", 128'(out_reg_we), 128'(h.reg_we));
      chk("reg", 128'(out_reg), 128'(h.reg_item));
`ifdef COSIM_MEM_LOG_EN
      chk("mem_we", 128'(out_mem_we), 128'(h.mem_we));
      chk("mem", 128'(out_mem), 128'(h.mem_item));
`endif
    end
  endtask

  // Check outputs at the falling edge, update the model, then cross the rising edge.
  task automatic tick();
    bit can, popd;
    @(negedge clk);
    check_state();
    can  = (model_q.size() + NumRet <= Depth);
    popd = (model_q.size() > 0) && out_ready;
    if (popd) begin
      void'(model_q.pop_front());
      model_seq++;
    end
    if (|ret_valid) begin
      if (can) begin
        for (int unsigned i = 0; i < NumRet; i++)
          if (ret_valid[i]) model_q.push_back(lane_entry(i));
      end else begin
        model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ret_valid = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_q.delete();
    model_seq = 0;
    model_ovf = 1'b0;
  endtask

  task automatic drain();
    ret_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 2 * Depth && model_q.size() > 0; k++) tick();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, 128'(count), 128'(0));
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_ready"}, 128'(ret_ready), 128'(1));
    chk({tag, "_seq"}, 128'(out_seq), 128'(0));
    chk({tag, "_ovf"}, 128'(ovf), 128'(0));
    chk({tag, "_pc"}, 128'(out_pc), 128'(0));
    chk({tag, "_reg_we"}, 128'(out_reg_we), 128'(0));
    chk({tag, "_reg"}, 128'(out_reg), 128'(0));
`ifdef COSIM_MEM_LOG_EN
    chk({tag, "_mem_we"}, 128'(out_mem_we), 128'(0));
    chk({tag, "_mem"}, 128'(out_mem), 128'(0));
`endif
  endtask

  initial begin
    int unsigned pushed;
    logic [XREG_W-1:0] next_pc;
    logic [NumRet-1:0] v;

    rst        = 1'b1;
    ret_valid  = '0;
    ret_pc     = '0;
    ret_reg_we = '0;
    ret_reg    = '0;
`ifdef COSIM_MEM_LOG_EN
    ret_mem_we = '0;
    ret_mem    = '0;
`endif
    out_ready  = 1'b0;
    model_seq  = 0;
    model_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    check_reset_values("rst0");

    // Single lane-0 push with a register (and memory) write.
    set_lane(0, 32'h8000_0000);
    ret_reg_we[0] = 1'b1;
    ret_reg[0]    = {5'd5, 32'h0000_1234};
`ifdef COSIM_MEM_LOG_EN
    ret_mem_we[0] = 1'b1;
    ret_mem[0]    = {32'h8000_1000, 4'd4, 32'h0};
`endif
    ret_valid = 2'b01;
    tick();
    ret_valid = '0;
    chk("tp1_valid", 128'(out_valid), 128'(1));
    chk("tp1_pc", 128'(out_pc), 128'(32'h8000_0000));
    chk("tp1_reg", 128'(out_reg), 128'({5'd5, 32'h0000_1234}));
    chk("tp1_seq", 128'(out_seq), 128'(0));
    chk("tp1_count", 128'(count), 128'(1));
`ifdef COSIM_MEM_LOG_EN
    chk("tp1_mem_we", 128'(out_mem_we), 128'(1));
    chk("tp1_mem_addr", 128'(out_mem.addr), 128'(32'h8000_1000));
    chk("tp1_mem_len", 128'(out_mem.len), 128'(4));
`endif
    drain();

    // Non-contiguous lanes are compacted in lane order.
    do_reset();
    out_ready = 1'b0;
    set_lane(1, 32'h100);
    ret_valid = 2'b10;
    tick();
    set_lane(0, 32'h104);
    set_lane(1, 32'h108);
    ret_valid = 2'b11;
    tick();
    ret_valid = '0;
    out_ready = 1'b1;
    chk("cmp_pc0", 128'(out_pc), 128'(32'h100));
    tick();
    chk("cmp_pc1", 128'(out_pc), 128'(32'h104));
    chk("cmp_seq1", 128'(out_seq), 128'(1));
    tick();
    chk("cmp_pc2", 128'(out_pc), 128'(32'h108));
    chk("cmp_seq2", 128'(out_seq), 128'(2));
    tick();

    // Fill to full with two lanes per cycle, then attempt an extra retire.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 32'h1000 + 32'(8 * k));
      set_lane(1, 32'h1004 + 32'(8 * k));
      ret_valid = 2'b11;
      tick();
      if (k == 6) begin
        chk("fill14_count", 128'(count), 128'(14));
        chk("fill14_ready", 128'(ret_ready), 128'(1));
      end
    end
    chk("full_count", 128'(count), 128'(16));
    chk("full_ready", 128'(ret_ready), 128'(0));
    tick();
    chk("ovf_set", 128'(ovf), 128'(1));
    chk("ovf_count", 128'(count), 128'(16));
    out_ready = 1'b1;
    tick();
    chk("full_pop_count", 128'(count), 128'(15));
    chk("full_pop_ovf", 128'(ovf), 128'(1));
    drain();

    // 40-entry stream with out_ready toggling; the source honours ret_ready.
    do_reset();
    pushed  = 0;
    next_pc = 32'h2000;
    for (int c = 0; c < 400 && pushed < 40; c++) begin
      v = NumRet'($urandom);
      if (!ret_ready) v = '0;
      if (40 - pushed < NumRet) v = v & 2'b01;
      for (int unsigned i = 0; i < NumRet; i++) begin
        if (v[i]) begin
          set_lane(i, next_pc);
          next_pc = next_pc + 32'd4;
          pushed++;
        end
      end
      ret_valid = v;
      out_ready = c[0];
      tick();
    end
    ret_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && model_q.size() > 1; k++) tick();
    chk("stream_last_seq", 128'(out_seq), 128'(39));
    chk("stream_last_pc", 128'(out_pc), 128'(32'h2000 + 32'd156));
    tick();
    chk("stream_empty", 128'(out_valid), 128'(0));

    // Unconstrained random traffic, including retires while stalled.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int unsigned i = 0; i < NumRet; i++) set_lane(i, $urandom);
      ret_valid = ($urandom_range(0, 3) == 0) ? '0 : NumRet'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Reset with seven entries in flight.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 32'h3000 + 32'(8 * k));
      set_lane(1, 32'h3004 + 32'(8 * k));
      ret_valid = (k == 3) ? 2'b01 : 2'b11;
      tick();
    end
    ret_valid = '0;
    out_ready = 1'b1;
    tick();
    chk("pre_rst_count", 128'(count), 128'(6));
    out_ready = 1'b0;
    set_lane(0, 32'h4000);
    ret_valid = 2'b01;
    tick();
    ret_valid = '0;
    chk("rst7_count", 128'(count), 128'(7));
    do_reset();
    check_reset_values("rst7");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
